// File: rtl/ysyx_mem_arb_if.sv
// ysyx_mem_arb_if: requester-side and downstream-bus signals of the memory arbiter
interface ysyx_mem_arb_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] ifu_araddr;
  logic            ifu_arvalid;
  logic            ifu_flush;
  logic [XLEN-1:0] ifu_rdata;
  logic            ifu_rvalid;
  logic [XLEN-1:0] lsu_araddr;
  logic            lsu_arvalid;
  logic [XLEN-1:0] lsu_rdata;
  logic            lsu_rvalid;
  logic [XLEN-1:0] lsu_awaddr;
  logic [XLEN-1:0] lsu_wdata;
  logic [3:0]      lsu_wstrb;
  logic            lsu_awvalid;
  logic            lsu_bvalid;
  logic [XLEN-1:0] bus_araddr;
  logic [XLEN-1:0] bus_awaddr;
  logic [XLEN-1:0] bus_wdata;
  logic [3:0]      bus_wstrb;
  logic            bus_arvalid;
  logic            bus_awvalid;
  logic            bus_arready;
  logic            bus_awready;
  logic [XLEN-1:0] bus_rdata;
  logic            bus_rvalid;
  logic            bus_bvalid;
  modport slave (
    input  ifu_araddr, ifu_arvalid, ifu_flush, lsu_araddr, lsu_arvalid,
           lsu_awaddr, lsu_wdata, lsu_wstrb, lsu_awvalid,
           bus_arready, bus_awready, bus_rdata, bus_rvalid, bus_bvalid,
    output ifu_rdata, ifu_rvalid, lsu_rdata, lsu_rvalid, lsu_bvalid,
           bus_araddr, bus_awaddr, bus_wdata, bus_wstrb, bus_arvalid, bus_awvalid
  );
  modport master (
    output ifu_araddr, ifu_arvalid, ifu_flush, lsu_araddr, lsu_arvalid,
           lsu_awaddr, lsu_wdata, lsu_wstrb, lsu_awvalid,
           bus_arready, bus_awready, bus_rdata, bus_rvalid, bus_bvalid,
    input  ifu_rdata, ifu_rvalid, lsu_rdata, lsu_rvalid, lsu_bvalid,
           bus_araddr, bus_awaddr, bus_wdata, bus_wstrb, bus_arvalid, bus_awvalid
  );
endinterface

// File: rtl/ysyx_mem_arb.sv
// ysyx_mem_arb: single-outstanding IFU/LSU arbiter onto one memory bus; define YSYX_ARB_RR_EN for IFU/LSU round-robin on ties
module ysyx_mem_arb #(parameter int XLEN = 32) (
  input logic clock,
  input logic reset,
  ysyx_mem_arb_if.slave m
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;
  state_t state, state_n;
  logic owner_ifu, drop, any_lsu, any_req, pick_ifu, rd_done;
  logic [XLEN-1:0] addr, wdata;
  logic [3:0] wstrb;
  assign any_lsu = m.lsu_awvalid || m.lsu_arvalid;
  assign any_req = any_lsu || m.ifu_arvalid;
`ifdef YSYX_ARB_RR_EN
  logic last_ifu;
  assign pick_ifu = m.ifu_arvalid && (!any_lsu || !last_ifu);
  // remember which class won the last grant so a tie alternates
  always_ff @(posedge clock)
    if (reset) last_ifu <= 1'b1;
    else if (state == IDLE && any_req) last_ifu <= pick_ifu;
`else
  assign pick_ifu = m.ifu_arvalid && !any_lsu;
`endif
  // next state: grant in IDLE, hold request until ready, wait for response
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !any_req ? IDLE : (m.lsu_awvalid && !pick_ifu) ? WR_REQ : RD_REQ;
      RD_REQ:  state_n = m.bus_arready ? RD_WAIT : RD_REQ;
      RD_WAIT: state_n = m.bus_rvalid ? IDLE : RD_WAIT;
      WR_REQ:  state_n = m.bus_awready ? WR_WAIT : WR_REQ;
      WR_WAIT: state_n = m.bus_bvalid ? IDLE : WR_WAIT;
      default: state_n = IDLE;
    endcase
  end
  // state register plus request latches, which only move while IDLE so the bus sees stable values
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      owner_ifu <= 1'b0;
      drop <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        owner_ifu <= pick_ifu;
        addr <= pick_ifu ? m.ifu_araddr : m.lsu_awvalid ? m.lsu_awaddr : m.lsu_araddr;
        wdata <= m.lsu_wdata;
        wstrb <= m.lsu_wstrb;
        drop <= 1'b0;
      end else if (owner_ifu && (state == RD_REQ || state == RD_WAIT) && m.ifu_flush) drop <= 1'b1;
    end
  assign rd_done = !reset && state == RD_WAIT && m.bus_rvalid;
  assign m.bus_araddr = addr;
  assign m.bus_awaddr = addr;
  assign m.bus_wdata = wdata;
  assign m.bus_wstrb = wstrb;
  assign m.bus_arvalid = !reset && state == RD_REQ;
  assign m.bus_awvalid = !reset && state == WR_REQ;
  assign m.ifu_rdata = m.bus_rdata;
  assign m.lsu_rdata = m.bus_rdata;
  assign m.ifu_rvalid = rd_done && owner_ifu && !drop && !m.ifu_flush;
  assign m.lsu_rvalid = rd_done && !owner_ifu;
  assign m.lsu_bvalid = !reset && state == WR_WAIT && m.bus_bvalid;
endmodule

// File: tb/tb_ysyx_mem_arb.sv
// tb_ysyx_mem_arb: vector table plus scoreboard and hand sequences for ysyx_mem_arb
module tb_ysyx_mem_arb;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  ysyx_mem_arb_if #(.XLEN(32)) bif();
  ysyx_mem_arb #(.XLEN(32)) dut (.clock(clock), .reset(reset), .m(bif));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic st, ld, f;
    logic [31:0] addr, data;
    logic [3:0] strb;
    int delay;
    logic [1:0] kind;
  } vec_t;
  typedef struct {
    logic [1:0] kind;
    logic [31:0] addr, data;
    logic [3:0] strb;
  } exp_t;
  exp_t sb[$];
  vec_t vecs[8];
  logic last_ifu_m = 1'b1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [31:0] pulses();
    return 32'({bif.ifu_rvalid, bif.lsu_rvalid, bif.lsu_bvalid});
  endfunction
  function automatic logic [31:0] reqs();
    return 32'({bif.bus_awvalid, bif.bus_arvalid});
  endfunction
  task automatic quiet();
    bif.ifu_arvalid = 0; bif.lsu_arvalid = 0; bif.lsu_awvalid = 0; bif.ifu_flush = 0;
    bif.bus_arready = 0; bif.bus_awready = 0; bif.bus_rvalid = 0; bif.bus_bvalid = 0;
  endtask
  task automatic run_vec(input vec_t v);
    exp_t e;
    logic [1:0] k;
    k = v.kind;
`ifdef YSYX_ARB_RR_EN
    if (v.f && (v.st || v.ld)) k = last_ifu_m ? (v.st ? 2'd0 : 2'd1) : 2'd2;
`endif
    if (v.f || v.st || v.ld) last_ifu_m = (k == 2'd2);
    @(negedge clock);
    bif.ifu_arvalid = v.f; bif.lsu_arvalid = v.ld; bif.lsu_awvalid = v.st;
    bif.ifu_araddr = v.addr; bif.lsu_araddr = v.addr ^ 32'h40; bif.lsu_awaddr = v.addr;
    bif.lsu_wdata = v.data; bif.lsu_wstrb = v.strb;
    e.kind = k; e.addr = (k == 2'd1) ? (v.addr ^ 32'h40) : v.addr; e.data = v.data; e.strb = v.strb;
    sb.push_back(e);
    #1 chk("grant_cycle_idle", reqs(), 0);
    @(negedge clock);
    quiet();
    bif.ifu_araddr = ~v.addr; bif.lsu_araddr = ~v.addr; bif.lsu_awaddr = ~v.addr;
    bif.lsu_wdata = ~v.data; bif.lsu_wstrb = ~v.strb;
    for (int i = 0; i <= v.delay; i++) begin
      if (i > 0) @(negedge clock);
      bif.bus_awready = (k == 2'd0) && (i == v.delay);
      bif.bus_arready = (k != 2'd0) && (i == v.delay);
      #1 chk("req_valid", reqs(), (k == 2'd0) ? 32'd2 : 32'd1);
      if (k == 2'd0) begin
        chk("awaddr", bif.bus_awaddr, e.addr);
        chk("wdata", bif.bus_wdata, e.data);
        chk("wstrb", 32'(bif.bus_wstrb), 32'(e.strb));
      end else chk("araddr", bif.bus_araddr, e.addr);
      chk("no_early_resp", pulses(), 0);
    end
    @(negedge clock);
    bif.bus_arready = 0; bif.bus_awready = 0;
    bif.bus_rvalid = (k != 2'd0); bif.bus_bvalid = (k == 2'd0); bif.bus_rdata = v.data;
    #1 chk("wait_no_req", reqs(), 0);
    if (sb.size() == 0) chk("sb_nonempty", 0, 1);
    else begin
      e = sb.pop_front();
      chk("resp_pulse", pulses(), (e.kind == 2'd0) ? 32'd1 : (e.kind == 2'd1) ? 32'd2 : 32'd4);
      if (e.kind == 2'd1) chk("lsu_rdata", bif.lsu_rdata, e.data);
      if (e.kind == 2'd2) chk("ifu_rdata", bif.ifu_rdata, e.data);
    end
    @(negedge clock);
    bif.bus_rvalid = 0; bif.bus_bvalid = 0;
    #1 chk("pulse_one_cycle", pulses(), 0);
    chk("back_idle", reqs(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    vecs[0] = '{0, 0, 1, 32'h3000_0000, 32'h0000_0413, 4'h0, 0, 2'd2};
    vecs[1] = '{0, 1, 0, 32'h1000_0008, 32'hCAFE_BABE, 4'h0, 1, 2'd1};
    vecs[2] = '{1, 0, 0, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 3, 2'd0};
    vecs[3] = '{0, 1, 1, 32'h2000_0000, 32'h1234_5678, 4'h0, 0, 2'd1};
    vecs[4] = '{0, 1, 1, 32'h2000_0010, 32'h0BAD_F00D, 4'h0, 2, 2'd1};
    vecs[5] = '{1, 1, 1, 32'h4000_0100, 32'hA5A5_5A5A, 4'h5, 0, 2'd0};
    vecs[6] = '{1, 0, 1, 32'h4000_0200, 32'h0F0F_F0F0, 4'h3, 1, 2'd0};
    vecs[7] = '{1, 1, 0, 32'h5000_0000, 32'h1111_2222, 4'hC, 0, 2'd0};
    quiet();
    bif.ifu_araddr = 0; bif.lsu_araddr = 0; bif.lsu_awaddr = 0;
    bif.lsu_wdata = 0; bif.lsu_wstrb = 0; bif.bus_rdata = 0;
    repeat (2) @(negedge clock);
    #1 chk("reset_pulses", pulses(), 0);
    chk("reset_reqs", reqs(), 0);
    @(negedge clock);
    reset = 0;
    #1 chk("post_reset_reqs", reqs(), 0);
    foreach (vecs[i]) run_vec(vecs[i]);
    // latency and a held valid re-requesting
    @(negedge clock);
    bif.ifu_arvalid = 1; bif.ifu_araddr = 32'h3000_0040;
    #1 chk("lat_n_idle", reqs(), 0);
    @(negedge clock);
    bif.bus_arready = 1;
    #1 chk("lat_n1_req", reqs(), 1);
    @(negedge clock);
    bif.bus_arready = 0; bif.bus_rvalid = 1; bif.bus_rdata = 32'h0000_0013;
    #1 chk("lat_n2_resp", pulses(), 4);
    @(negedge clock);
    bif.bus_rvalid = 0;
    #1 chk("lat_n3_idle", reqs(), 0);
    chk("lat_n3_nopulse", pulses(), 0);
    @(negedge clock);
    bif.ifu_arvalid = 0; bif.bus_arready = 1;
    #1 chk("rereq_n4", reqs(), 1);
    @(negedge clock);
    bif.bus_arready = 0; bif.bus_rvalid = 1;
    #1 chk("rereq_resp", pulses(), 4);
    @(negedge clock);
    bif.bus_rvalid = 0;
    last_ifu_m = 1'b1;
    // flush during RD_WAIT drops the fetch response
    @(negedge clock);
    bif.ifu_arvalid = 1; bif.ifu_araddr = 32'h3000_0080;
    @(negedge clock);
    bif.ifu_arvalid = 0; bif.bus_arready = 1;
    @(negedge clock);
    bif.bus_arready = 0; bif.ifu_flush = 1;
    #1 chk("flush_wait_nopulse", pulses(), 0);
    @(negedge clock);
    bif.ifu_flush = 0; bif.bus_rvalid = 1; bif.bus_rdata = 32'h1234_0000;
    #1 chk("flush_dropped", pulses(), 0);
    @(negedge clock);
    bif.bus_rvalid = 0;
    #1 chk("flush_idle", reqs(), 0);
    run_vec('{0, 0, 1, 32'h3000_00C0, 32'h0000_0093, 4'h0, 0, 2'd2});
    // bus responses outside the wait states are ignored
    @(negedge clock);
    bif.bus_rvalid = 1; bif.bus_bvalid = 1;
    #1 chk("idle_resp_ignored", pulses(), 0);
    bif.lsu_arvalid = 1; bif.lsu_araddr = 32'h6000_0000;
    @(negedge clock);
    bif.lsu_arvalid = 0;
    #1 chk("rdreq_resp_ignored", pulses(), 0);
    chk("rdreq_held", reqs(), 1);
    @(negedge clock);
    bif.bus_rvalid = 0; bif.bus_bvalid = 0; bif.bus_arready = 1;
    @(negedge clock);
    bif.bus_arready = 0; bif.bus_rvalid = 1; bif.bus_rdata = 32'h5555_AAAA;
    #1 chk("late_lsu_resp", pulses(), 2);
    chk("late_lsu_rdata", bif.lsu_rdata, 32'h5555_AAAA);
    @(negedge clock);
    bif.bus_rvalid = 0;
    // reset while waiting for read data abandons the transaction
    @(negedge clock);
    bif.ifu_arvalid = 1; bif.ifu_araddr = 32'h3000_0100;
    @(negedge clock);
    bif.ifu_arvalid = 0; bif.bus_arready = 1;
    @(negedge clock);
    bif.bus_arready = 0; reset = 1; bif.bus_rvalid = 1;
    #1 chk("reset_wait_nopulse", pulses(), 0);
    @(negedge clock);
    reset = 0;
    #1 chk("after_reset_nopulse", pulses(), 0);
    chk("after_reset_idle", reqs(), 0);
    @(negedge clock);
    bif.bus_rvalid = 0;
    last_ifu_m = 1'b1;
    run_vec('{0, 1, 0, 32'h7000_0000, 32'hFEED_0001, 4'h0, 0, 2'd1});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
